parking_controller: RTL and testbench

- Central sequencer for the parking lot. It arbitrates car entry and exit requests, allocates and frees slots, and times each slot's occupancy.
- It runs the barrier gate FSM.
- It is the source of the capacity, empty_slot, minutes and seconds values consumed by the multiplexed 7-segment display. It sits between the entry/exit sensors or buttons and the display block.

---
 rtl/parking_pkg.sv | 7 +
 rtl/slot_timer.sv | 43 ++++
 rtl/parking_controller.sv | 164 ++++++++++++++++
 tb/tb_parking_controller.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// parking_pkg: shared FSM state type and timing limits for the parking controller
package parking_pkg;
    typedef enum logic [1:0] {IDLE, PASS, HOLD} state_t;
    localparam int MAX_SLOTS = 4;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
endpackage

// File: rtl/slot_timer.sv
// slot_timer: per-slot minutes:seconds occupancy counter, saturating at 59:59
module slot_timer
    import parking_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       tick,
    output logic [5:0] minutes,
    output logic [5:0] seconds
);
    logic [5:0] min_q, min_d, sec_q, sec_d;
    logic       sat;

    assign sat     = (min_q == 6'(MIN_MAX)) && (sec_q == 6'(SEC_MAX));
    assign minutes = min_q;
    assign seconds = sec_q;

    // Advance on tick while occupied; a clear or a free slot pins the timer at 00:00
    always_comb begin
        min_d = min_q;
        sec_d = sec_q;
        if (clr || !en) begin
            min_d = '0;
            sec_d = '0;
        end else if (tick && !sat) begin
            sec_d = (sec_q == 6'(SEC_MAX)) ? '0 : sec_q + 6'd1;
            min_d = (sec_q == 6'(SEC_MAX)) ? min_q + 6'd1 : min_q;
        end
    end

    // Timer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q <= '0;
            sec_q <= '0;
        end else begin
            min_q <= min_d;
            sec_q <= sec_d;
        end
    end
endmodule

// File: rtl/parking_controller.sv
// parking_controller: arbitrates entry/exit, allocates slots, runs the gate FSM and times occupancy
module parking_controller
    import parking_pkg::*;
#(
    parameter int SLOTS         = 4,
    parameter int TICKS_PER_SEC = 500,
    parameter int GATE_TICKS    = 1000
) (
    input  logic       clk_500Hz,
    input  logic       reset,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic [1:0] exit_slot,
    output logic       gate_open,
    output logic       entry_grant,
    output logic [1:0] assigned_slot,
    output logic       exit_ack,
    output logic       error,
    output logic       full,
    output logic [2:0] capacity,
    output logic [1:0] empty_slot,
    output logic [5:0] minutes,
    output logic [5:0] seconds
);
    localparam int TW = $clog2(TICKS_PER_SEC + 1);
    localparam int GW = $clog2(GATE_TICKS + 1);

    state_t                 state_q, state_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic [GW-1:0]          gcnt_q, gcnt_d;
    logic [MAX_SLOTS-1:0]   occ_q, occ_d, clr;
    logic [1:0]             slot_q, slot_d, empty_q, empty_d, free_idx;
    logic                   grant_q, grant_d, ack_q, ack_d, err_q, err_d;
    logic                   full_q, full_d, free_ok, exit_ok, tick;
    logic [2:0]             cap_q, cap_d;
    logic [5:0]             min_q, min_d, sec_q, sec_d;
    logic [5:0]             t_min [MAX_SLOTS];
    logic [5:0]             t_sec [MAX_SLOTS];

    assign tick          = tcnt_q == TW'(TICKS_PER_SEC - 1);
    assign tcnt_d        = tick ? '0 : tcnt_q + TW'(1);
    assign exit_ok       = (int'(exit_slot) < SLOTS) && occ_q[exit_slot];
    assign gate_open     = state_q == PASS;
    assign entry_grant   = grant_q;
    assign exit_ack      = ack_q;
    assign error         = err_q;
    assign assigned_slot = slot_q;
    assign full          = full_q;
    assign capacity      = cap_q;
    assign empty_slot    = empty_q;
    assign minutes       = min_q;
    assign seconds       = sec_q;

    for (genvar g = 0; g < MAX_SLOTS; g++) begin : g_slot
        if (g < SLOTS) begin : g_timer
            slot_timer u_timer (
                .clk     (clk_500Hz),
                .rst_n   (reset),
                .clr     (clr[g]),
                .en      (occ_q[g]),
                .tick    (tick),
                .minutes (t_min[g]),
                .seconds (t_sec[g])
            );
        end else begin : g_unused
            assign t_min[g] = '0;
            assign t_sec[g] = '0;
        end
    end

    // Lowest-index free slot and free-slot count from the occupancy vector
    always_comb begin
        free_ok  = 1'b0;
        free_idx = '0;
        cap_d    = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!occ_q[i]) begin
                free_ok  = 1'b1;
                free_idx = 2'(i);
            end
            cap_d = cap_d + 3'(!occ_q[i]);
        end
        full_d  = !free_ok;
        empty_d = free_idx;
    end

    // Gate FSM: arbitrate in IDLE (exit wins), hold gate open in PASS, wait for release in HOLD
    always_comb begin
        state_d = state_q;
        gcnt_d  = '0;
        occ_d   = occ_q;
        clr     = '0;
        slot_d  = slot_q;
        grant_d = 1'b0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        min_d   = min_q;
        sec_d   = sec_q;
        case (state_q)
            IDLE: begin
                if (exit_req) begin
                    if (exit_ok) begin
                        occ_d[exit_slot] = 1'b0;
                        clr[exit_slot]   = 1'b1;
                        min_d            = t_min[exit_slot];
                        sec_d            = t_sec[exit_slot];
                        ack_d            = 1'b1;
                        state_d          = PASS;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (entry_req) begin
                    if (free_ok) begin
                        occ_d[free_idx] = 1'b1;
                        slot_d          = free_idx;
                        grant_d         = 1'b1;
                        state_d         = PASS;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            PASS: begin
                gcnt_d  = (gcnt_q == GW'(GATE_TICKS - 1)) ? '0 : gcnt_q + GW'(1);
                state_d = (gcnt_q == GW'(GATE_TICKS - 1)) ? HOLD : PASS;
            end
            HOLD:    state_d = (!entry_req && !exit_req) ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end

    // Controller state, pulses, latched duration and registered status
    always_ff @(posedge clk_500Hz or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            gcnt_q  <= '0;
            occ_q   <= '0;
            slot_q  <= '0;
            grant_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            min_q   <= '0;
            sec_q   <= '0;
            cap_q   <= 3'(SLOTS);
            full_q  <= 1'b0;
            empty_q <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            gcnt_q  <= gcnt_d;
            occ_q   <= occ_d;
            slot_q  <= slot_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            cap_q   <= cap_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end
endmodule

// File: tb/tb_parking_controller.sv
// tb_parking_controller: directed-vector self-checking bench for parking_controller
module tb_parking_controller;
    logic       clk_500Hz = 1'b0;
    logic       reset     = 1'b1;
    logic       entry_req = 1'b0;
    logic       exit_req  = 1'b0;
    logic [1:0] exit_slot = '0;
    logic       gate_open, entry_grant, exit_ack, error, full;
    logic [1:0] assigned_slot, empty_slot;
    logic [2:0] capacity;
    logic [5:0] minutes, seconds;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         grant_cyc = 0;
    int         n;

    parking_controller dut (
        .clk_500Hz     (clk_500Hz),
        .reset         (reset),
        .entry_req     (entry_req),
        .exit_req      (exit_req),
        .exit_slot     (exit_slot),
        .gate_open     (gate_open),
        .entry_grant   (entry_grant),
        .assigned_slot (assigned_slot),
        .exit_ack      (exit_ack),
        .error         (error),
        .full          (full),
        .capacity      (capacity),
        .empty_slot    (empty_slot),
        .minutes       (minutes),
        .seconds       (seconds)
    );

    always #5 clk_500Hz = ~clk_500Hz;

    always @(posedge clk_500Hz) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk_500Hz);
        #1;
    endtask

    task automatic wait_gate_closed(output int cnt);
        cnt = 0;
        while (gate_open && cnt < 3000) begin
            step(1);
            cnt++;
        end
        check("gate_close_timeout", 32'(cnt < 3000), 1);
    endtask

    task automatic do_entry(input logic [1:0] slot);
        int k;
        entry_req = 1'b1;
        step(1);
        grant_cyc = cyc;
        check("entry_grant", 32'(entry_grant), 1);
        check("assigned_slot", 32'(assigned_slot), 32'(slot));
        check("gate_rise_entry", 32'(gate_open), 1);
        entry_req = 1'b0;
        step(1);
        check("grant_pulse_width", 32'(entry_grant), 0);
        wait_gate_closed(k);
        check("gate_open_cycles", 32'(k + 1), 1000);
        step(1);
    endtask

    task automatic do_exit(input logic [1:0] slot);
        int k;
        exit_req  = 1'b1;
        exit_slot = slot;
        step(1);
        check("exit_ack", 32'(exit_ack), 1);
        check("gate_rise_exit", 32'(gate_open), 1);
        exit_req = 1'b0;
        step(1);
        check("ack_pulse_width", 32'(exit_ack), 0);
        wait_gate_closed(k);
        step(1);
    endtask

    initial begin
        #1 reset = 1'b0;
        #20;
        check("rst_gate_low", 32'(gate_open), 0);
        check("rst_capacity_low", 32'(capacity), 4);
        #3 reset = 1'b1;
        step(2);
        check("rst_capacity", 32'(capacity), 4);
        check("rst_full", 32'(full), 0);
        check("rst_empty_slot", 32'(empty_slot), 0);
        check("rst_gate", 32'(gate_open), 0);
        check("rst_minutes", 32'(minutes), 0);
        check("rst_seconds", 32'(seconds), 0);
        check("rst_assigned", 32'(assigned_slot), 0);
        check("rst_error", 32'(error), 0);

        do_entry(2'd0);
        step(1);
        check("cap_after_first", 32'(capacity), 3);
        check("empty_after_first", 32'(empty_slot), 1);

        for (int s = 1; s < 4; s++) do_entry(2'(s));
        check("full_set", 32'(full), 1);
        check("cap_zero", 32'(capacity), 0);
        check("empty_when_full", 32'(empty_slot), 0);

        entry_req = 1'b1;
        step(1);
        check("reject_error", 32'(error), 1);
        check("reject_gate", 32'(gate_open), 0);
        check("reject_grant", 32'(entry_grant), 0);
        entry_req = 1'b0;
        step(1);
        check("error_pulse_width", 32'(error), 0);
        check("cap_after_reject", 32'(capacity), 0);

        for (int s = 3; s >= 0; s--) do_exit(2'(s));
        step(1);
        check("cap_all_free", 32'(capacity), 4);
        check("full_cleared", 32'(full), 0);

        do_entry(2'd0);
        while (cyc < grant_cyc + 37500) step(1);
        exit_req  = 1'b1;
        exit_slot = 2'd0;
        step(1);
        check("dur_exit_ack", 32'(exit_ack), 1);
        check("dur_minutes", 32'(minutes), 1);
        check("dur_seconds", 32'(seconds), 15);
        exit_req = 1'b0;
        wait_gate_closed(n);
        step(2);
        check("dur_capacity", 32'(capacity), 4);

        do_entry(2'd0);
        entry_req = 1'b1;
        exit_req  = 1'b1;
        exit_slot = 2'd0;
        step(1);
        check("both_exit_first", 32'(exit_ack), 1);
        check("both_no_grant", 32'(entry_grant), 0);
        check("both_gate", 32'(gate_open), 1);
        wait_gate_closed(n);
        step(5);
        check("hold_gate_closed", 32'(gate_open), 0);
        check("hold_no_grant", 32'(entry_grant), 0);
        check("hold_no_error", 32'(error), 0);
        entry_req = 1'b0;
        exit_req  = 1'b0;
        step(1);
        entry_req = 1'b1;
        step(1);
        check("after_hold_grant", 32'(entry_grant), 1);
        check("after_hold_slot", 32'(assigned_slot), 0);
        entry_req = 1'b0;
        wait_gate_closed(n);
        step(2);
        check("cap_after_reentry", 32'(capacity), 3);

        exit_req  = 1'b1;
        exit_slot = 2'd2;
        step(1);
        check("bad_exit_error", 32'(error), 1);
        check("bad_exit_ack", 32'(exit_ack), 0);
        check("bad_exit_gate", 32'(gate_open), 0);
        exit_req = 1'b0;
        step(2);
        check("bad_exit_cap", 32'(capacity), 3);
        check("bad_exit_empty", 32'(empty_slot), 1);

        entry_req = 1'b1;
        step(1);
        check("pre_reset_gate", 32'(gate_open), 1);
        check("pre_reset_slot", 32'(assigned_slot), 1);
        entry_req = 1'b0;
        step(10);
        #2 reset = 1'b0;
        #1;
        check("async_gate", 32'(gate_open), 0);
        check("async_capacity", 32'(capacity), 4);
        check("async_full", 32'(full), 0);
        check("async_minutes", 32'(minutes), 0);
        check("async_seconds", 32'(seconds), 0);
        check("async_assigned", 32'(assigned_slot), 0);
        #2 reset = 1'b1;
        step(2);
        check("post_reset_gate", 32'(gate_open), 0);
        check("post_reset_empty", 32'(empty_slot), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
